// File: rtl/mult_seq_mac_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier / MAC.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Iteration counter width for a given operand width (counts WIDTH-1 down to 0).
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  // Magnitude of a width-bit operand held in the low bits of x; the most
  // negative value maps to 2^(width-1) as an unsigned number.
  function automatic logic [63:0] abs_w(input logic [63:0] x, input int width,
                                        input logic signed_en);
    logic [63:0] mask;
    logic [63:0] r;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    r = x & mask;
    if (signed_en && r[width-1]) r = (~r + 64'd1) & mask;
    return r;
  endfunction

endpackage

// File: rtl/mult_seq_mac_shift_reg.sv
// (2W+1)-bit product/shift register; bit 2W catches the carry of the upper add.
module mult_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic               i_add,
  input  logic               i_shift,
  input  logic               i_add_shift,
  input  logic [WIDTH-1:0]   i_lsb_in,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH:0]   o_sr
);

  logic [2*WIDTH:0] r_sr;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH:0] w_added;

  assign w_sum   = r_sr[2*WIDTH:WIDTH] + {1'b0, i_mcand};
  assign w_added = {w_sum, r_sr[WIDTH-1:0]};
  assign o_sr    = r_sr;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sr <= '0;
    end else if (i_clr) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= {{(WIDTH+1){1'b0}}, i_lsb_in};
    end else if (i_add) begin
      r_sr <= w_added;
    end else if (i_shift) begin
      r_sr <= r_sr >> 1;
    end else if (i_add_shift) begin
      r_sr <= w_added >> 1;
    end
  end

endmodule

// File: rtl/mult_seq_mac.sv
// Sequential signed/unsigned shift-add multiplier with optional accumulate into
// the previous product (HI/LO style). Fixed latency of WIDTH+2 cycles.
module mult_seq_mac
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_is_signed,
  input  logic                 i_accumulate,
  input  logic                 i_clr,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product,
  output logic [1:0]           o_dbg_state
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [PW-1:0]      r_product;
  logic [PW:0]        w_sr;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [PW-1:0]      w_raw, w_res;
  logic               w_accept, w_shift, w_add_shift;

  assign w_abs_a = WIDTH'(abs_w(64'(i_a), WIDTH, i_is_signed));
  assign w_abs_b = WIDTH'(abs_w(64'(i_b), WIDTH, i_is_signed));
  assign w_raw   = w_sr[PW-1:0];
  assign w_res   = r_neg ? (~w_raw + PW'(1)) : w_raw;

  // Handshake: i_start is taken on any edge where the FSM is in IDLE or DONE
  // (o_busy=0) and i_clr=0; o_done pulses for one cycle with o_product valid.
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_add_shift = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = CALC;
        end
      end
      CALC: begin
        o_busy = 1'b1;
        if (w_sr[0]) w_add_shift = 1'b1;
        else         w_shift     = 1'b1;
        if (r_cnt == '0) w_next = FIX;
      end
      FIX: begin
        o_busy = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = CALC;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    if (i_clr) begin
      w_next      = IDLE;
      w_accept    = 1'b0;
      w_shift     = 1'b0;
      w_add_shift = 1'b0;
    end
  end

  // The accumulate base is r_product itself: it cannot change between accept and FIX.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_acc     <= 1'b0;
      r_mcand   <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      if (i_clr) begin
        r_cnt     <= '0;
        r_neg     <= 1'b0;
        r_acc     <= 1'b0;
        r_product <= '0;
      end else if (w_accept) begin
        r_cnt   <= CNT_LAST;
        r_neg   <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
        r_acc   <= i_accumulate;
        r_mcand <= w_abs_a;
      end else if (r_state == CALC && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end else if (r_state == FIX) begin
        r_product <= r_acc ? (r_product + w_res) : w_res;
      end
    end
  end

  mult_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clock       (clock),
    .rst         (rst),
    .i_clr       (i_clr),
    .i_load      (w_accept),
    .i_add       (1'b0),
    .i_shift     (w_shift),
    .i_add_shift (w_add_shift),
    .i_lsb_in    (w_abs_b),
    .i_mcand     (r_mcand),
    .o_sr        (w_sr)
  );

  assign o_product   = r_product;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_seq_mac.sv
// Bench for mult_seq_mac: directed timing/boundary cases plus random MAC traffic
// against an arithmetic reference, with a done-driven scoreboard.
module tb_mult_seq_mac;

  localparam int W  = 16;
  localparam int PW = 2 * W;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          is_signed = 1'b0;
  logic          accumulate = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done;
  logic [PW-1:0] product;
  logic [1:0]    dbg_state;

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] model_prod = '0;

  mult_seq_mac #(.WIDTH(W)) dut (
    .clock        (clock),
    .rst          (rst),
    .i_start      (start),
    .i_is_signed  (is_signed),
    .i_accumulate (accumulate),
    .i_clr        (clr),
    .i_a          (a),
    .i_b          (b),
    .o_busy       (busy),
    .o_done       (done),
    .o_product    (product),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic sgn);
    longint p;
    if (sgn) p = longint'($signed(x)) * longint'($signed(y));
    else     p = longint'(x) * longint'(y);
    return p[PW-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%0h expected=no_done", product);
      end else begin
        check("sb_product", 64'(product), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic sgn, input logic acc);
    logic [PW-1:0] r;
    a = x; b = y; is_signed = sgn; accumulate = acc; start = 1'b1;
    r = ref_mul(x, y, sgn);
    if (acc) r = model_prod + r;
    model_prod = r;
    exp_q.push_back(r);
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sgn, input logic acc);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy) check("wait_idle_timeout", 64'(busy), 64'(0));
    issue(x, y, sgn, acc);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Full-latency check; a stray start is pulsed at cycle glitch_k (0 = none).
  task automatic timed_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn,
                          input logic acc, input int glitch_k, input logic [PW-1:0] lit);
    issue(x, y, sgn, acc);
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clock);
      check($sformatf("busy_k%0d", k), 64'(busy), 64'(k <= W + 1));
      check($sformatf("done_k%0d", k), 64'(done), 64'(k == W + 2));
      if (k == glitch_k) begin
        start = 1'b1; a = 16'd7; b = 16'd7;
      end else begin
        start = 1'b0;
      end
    end
    check("product_literal", 64'(product), 64'(lit));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    @(negedge clock);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clock);
    check("rst_product", 64'(product), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    rst = 1'b0;
    @(negedge clock);

    timed_op(16'd3, 16'd5, 1'b0, 1'b0, 0, 32'h0000000F);
    timed_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 0, 32'hFFFE0001);
    timed_op(16'hFFFD, 16'h0005, 1'b1, 1'b0, 0, 32'hFFFFFFF1);
    timed_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0, 32'h40000000);
    timed_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0, 32'hFFFF8000);
    timed_op(16'd0, 16'd1234, 1'b0, 1'b0, 0, 32'h00000000);

    // accumulate chain
    timed_op(16'd3, 16'd5, 1'b0, 1'b0, 0, 32'h0000000F);
    timed_op(16'd2, 16'd4, 1'b0, 1'b1, 0, 32'h00000017);
    @(negedge clock);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    model_prod = '0;
    check("clr_idle_product", 64'(product), 64'(0));
    timed_op(16'hFFFF, 16'h0001, 1'b1, 1'b1, 0, 32'hFFFFFFFF);
    timed_op(16'd1, 16'd1, 1'b0, 1'b1, 0, 32'h00000000);

    // start while busy ignored, then back-to-back start in DONE
    timed_op(16'd3, 16'd5, 1'b0, 1'b0, 5, 32'h0000000F);
    timed_op(16'd2, 16'd3, 1'b0, 1'b0, 0, 32'h00000006);

    // clr mid-operation aborts with no done
    a = 16'd9; b = 16'd9; is_signed = 1'b0; accumulate = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    model_prod = '0;
    check("clr_abort_busy", 64'(busy), 64'(0));
    check("clr_abort_product", 64'(product), 64'(0));
    check("clr_abort_done", 64'(done), 64'(0));
    a = 16'd5; b = 16'd5; start = 1'b1; clr = 1'b1;
    @(negedge clock);
    start = 1'b0; clr = 1'b0;
    check("clr_start_busy", 64'(busy), 64'(0));
    check("clr_start_state", 64'(dbg_state), 64'(0));
    repeat (W + 6) @(negedge clock);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();

    // asynchronous reset mid-CALC
    timed_op(16'd3, 16'd5, 1'b0, 1'b0, 0, 32'h0000000F);
    @(negedge clock);
    a = 16'd7; b = 16'd7; is_signed = 1'b0; accumulate = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    #2 rst = 1'b1;
    #1;
    check("arst_product", 64'(product), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    @(negedge clock);
    rst = 1'b0;
    model_prod = '0;
    @(negedge clock);
    timed_op(16'd3, 16'd5, 1'b0, 1'b0, 0, 32'h0000000F);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
